// File: rtl/page_sel_pkg.sv
// page_sel_pkg: shared constants and helpers for the page selector.
//   idx_width : width of a page index, max(1, clog2(n))
//   one_hot   : 16-bit one-hot decode of a 4-bit page index
//   RST_IDX   : page selected out of reset
package page_sel_pkg;

    localparam int unsigned MAX_PAGES = 16;
    localparam int unsigned RST_IDX   = 0;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_PAGES-1:0] one_hot(input logic [3:0] idx);
        logic [MAX_PAGES-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/page_sel_if.sv
// page_sel_if: button inputs and page-select outputs of the page selector.
//   bt_next / bt_pre / bt_auto : raw push-buttons, active-high, asynchronous
//   enable_sw                  : one-hot plot enable
//   page_idx                   : current page index
//   auto_on                    : auto-advance active
// slave is the selector side, master the button/display side.
interface page_sel_if
    import page_sel_pkg::*;
#(
    parameter int unsigned N_PAGES = 4
);
    localparam int unsigned IW = idx_width(N_PAGES);

    logic               bt_next;
    logic               bt_pre;
    logic               bt_auto;
    logic [N_PAGES-1:0] enable_sw;
    logic [IW-1:0]      page_idx;
    logic               auto_on;

    modport slave (
        input  bt_next,
        input  bt_pre,
        input  bt_auto,
        output enable_sw,
        output page_idx,
        output auto_on
    );

    modport master (
        output bt_next,
        output bt_pre,
        output bt_auto,
        input  enable_sw,
        input  page_idx,
        input  auto_on
    );

endinterface

// File: rtl/page_sel_key_debounce.sv
// key_debounce: synchronises one raw button and turns a debounced press into a
// single-cycle pulse.
//   sysclk    : system clock
//   rst_n     : asynchronous active-low reset (already release-synchronised)
//   raw       : raw asynchronous button level
//   pressed_p : one-cycle pulse on each accepted 0->1 transition
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic raw,
    output logic pressed_p
);

    localparam int unsigned CW = (DEBOUNCE_CYC <= 2) ? 1 : $clog2(DEBOUNCE_CYC);

    logic [1:0]    sync_q;
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          differ, done;

    assign differ = sync_q[1] != state_q;
    assign done   = differ && (cnt_q == CW'(DEBOUNCE_CYC - 1));

    always_comb begin
        cnt_d   = '0;
        state_d = state_q;
        press_d = 1'b0;
        if (done) begin
            state_d = sync_q[1];
            press_d = sync_q[1];
        end else if (differ) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign pressed_p = press_q;

endmodule

// File: rtl/page_sel.sv
// page_sel: page/plot selector with Next/Previous/Auto buttons.
//   sysclk : system clock
//   rst_n  : asynchronous active-low reset, release synchronised internally
//   bus    : page_sel_if.slave carrying raw buttons and enable_sw/page_idx/auto_on
module page_sel
    import page_sel_pkg::*;
#(
    parameter int unsigned N_PAGES      = 4,
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned AUTO_PERIOD  = 268435456,
    parameter int unsigned WRAP         = 1
) (
    input  logic        sysclk,
    input  logic        rst_n,
    page_sel_if.slave   bus
);

    localparam int unsigned IW = idx_width(N_PAGES);
    localparam int unsigned TW = (AUTO_PERIOD <= 2) ? 1 : $clog2(AUTO_PERIOD);
    localparam logic [IW-1:0] LAST = IW'(N_PAGES - 1);

    logic [1:0]    rst_sync_q;
    logic          rst_int_n;
    logic          next_p, pre_p, auto_p;
    logic [IW-1:0] idx_q, idx_d;
    logic          auto_q, auto_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          step_up, step_dn, manual, tick, auto_step;

    // Assert asynchronously, release two clocks later.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_next (
        .sysclk    (sysclk),
        .rst_n     (rst_int_n),
        .raw       (bus.bt_next),
        .pressed_p (next_p)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_pre (
        .sysclk    (sysclk),
        .rst_n     (rst_int_n),
        .raw       (bus.bt_pre),
        .pressed_p (pre_p)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_auto (
        .sysclk    (sysclk),
        .rst_n     (rst_int_n),
        .raw       (bus.bt_auto),
        .pressed_p (auto_p)
    );

    // Next and Previous together cancel out.
    assign step_up   = next_p && !pre_p;
    assign step_dn   = pre_p && !next_p;
    assign manual    = step_up || step_dn;
    assign tick      = auto_q && (timer_q == TW'(AUTO_PERIOD - 1));
    assign auto_step = tick && !manual;

    always_comb begin
        idx_d  = idx_q;
        auto_d = auto_q ^ auto_p;
        if (step_up || auto_step) begin
            if (idx_q == LAST) begin
                if (WRAP != 0) begin
                    idx_d = '0;
                end else if (auto_step) begin
                    // Auto-advance has nowhere to go: stop it.
                    auto_d = 1'b0;
                end
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else if (step_dn) begin
            if (idx_q == '0) begin
                if (WRAP != 0) begin
                    idx_d = LAST;
                end
            end else begin
                idx_d = idx_q - IW'(1);
            end
        end
    end

    always_comb begin
        timer_d = timer_q + TW'(1);
        if (!auto_q || auto_p || manual || tick) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge sysclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            idx_q   <= IW'(RST_IDX);
            auto_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            idx_q   <= idx_d;
            auto_q  <= auto_d;
            timer_q <= timer_d;
        end
    end

    assign bus.page_idx  = idx_q;
    assign bus.auto_on   = auto_q;
    assign bus.enable_sw = N_PAGES'(one_hot(4'(idx_q)));

endmodule
